// File: rtl/counter_timer_ctrl.sv
// counter_timer_ctrl
//
// Programmable sequencer for the counter datapath. A start pulse latches the
// period, prescale and mode, then an internal count advances on every
// prescaled tick. done pulses for one cycle at the end of each period; the
// run either ends (one-shot) or reloads (periodic). pause freezes the run,
// stop aborts it, and a new start restarts it from zero with new settings.
//
// Parameters
//   CNT_W     count / period width
//   PRE_W     prescaler width
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   start      pulse: latch period/prescale/mode and (re)start the count
//   stop       abort the run and return to idle
//   pause      level: hold the run while high
//   mode       0 = one-shot, 1 = periodic (auto-reload)
//   period     terminal count P (a start with P == 0 is rejected)
//   prescale   S; one tick every S+1 counting cycles
//   tick       combinational; high in the cycle whose edge advances the count
//   count_out  current count, registered
//   busy       registered; high while a run is active or paused
//   done       registered; one-cycle pulse at each period end
//   cfg_err    registered; one-cycle pulse when a start is rejected
module counter_timer_ctrl #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick,
    output logic [CNT_W-1:0] count_out,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;

    // Configuration captured at an accepted start
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] per_d;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             mode_q;
    logic             mode_d;

    // Run-time counters and registered pulses
    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_cnt_d;
    logic [CNT_W-1:0] count_d;
    logic             done_d;
    logic             cfg_err_d;

    logic             start_ok;
    logic             pre_hit;

    assign start_ok = start && (period != '0);
    assign pre_hit  = (pre_cnt == pre_q);

    // Any control input that outranks the tick suppresses it for this cycle.
    assign tick = (state == ST_RUN) && !stop && !start && !pause && pre_hit;

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            per_q     <= '0;
            pre_q     <= '0;
            mode_q    <= 1'b0;
            pre_cnt   <= '0;
            count_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_d;
            per_q     <= per_d;
            pre_q     <= pre_d;
            mode_q    <= mode_d;
            pre_cnt   <= pre_cnt_d;
            count_out <= count_d;
            busy      <= (state_d != ST_IDLE);
            done      <= done_d;
            cfg_err   <= cfg_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update, priority stop > start > pause > tick
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state;
        per_d     = per_q;
        pre_d     = pre_q;
        mode_d    = mode_q;
        pre_cnt_d = pre_cnt;
        count_d   = count_out;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        if (stop) begin
            // stop also masks a simultaneous start; in idle it does nothing.
            if (state != ST_IDLE) begin
                state_d   = ST_IDLE;
                count_d   = '0;
                pre_cnt_d = '0;
            end
        end else if (start) begin
            if (start_ok) begin
                per_d     = period;
                pre_d     = prescale;
                mode_d    = mode;
                count_d   = '0;
                pre_cnt_d = '0;
                state_d   = ST_RUN;
            end else begin
                // Rejected start: the current run is left exactly as it was,
                // so this cycle is a frozen cycle for the prescaler.
                cfg_err_d = 1'b1;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (pre_hit) begin
                        pre_cnt_d = '0;
                        if (count_out != per_q) begin
                            count_d = count_out + CNT_W'(1);
                        end else begin
                            done_d = 1'b1;
                            if (mode_q) begin
                                count_d = '0;
                            end else begin
                                // One-shot: count_out keeps P in idle.
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        pre_cnt_d = pre_cnt + PRE_W'(1);
                    end
                end
                ST_PAUSED: begin
                    // The release cycle itself is still frozen; counting
                    // resumes from the held values on the following cycle.
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Self-checking bench for counter_timer_ctrl. Directed scenarios check the
// timing rules with constants; a randomized run checks every cycle against a
// reference model that tracks elapsed counting cycles and derives ticks,
// count and done from plain division/modulo arithmetic.
module tb_counter_timer_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned PRE_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             pause;
    logic             mode;
    logic [CNT_W-1:0] period;
    logic [PRE_W-1:0] prescale;
    logic             tick;
    logic [CNT_W-1:0] count_out;
    logic             busy;
    logic             done;
    logic             cfg_err;

    int checks   = 0;
    int failures = 0;

    // Reference model
    bit               m_active;
    bit               m_frozen;
    int unsigned      m_elapsed;
    int unsigned      m_per;
    int unsigned      m_pre;
    bit               m_periodic;
    logic [CNT_W-1:0] m_count;
    bit               m_done;
    bit               m_err;
    bit               m_tick;
    logic             obs_tick;

    counter_timer_ctrl #(
        .CNT_W(CNT_W),
        .PRE_W(PRE_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .mode     (mode),
        .period   (period),
        .prescale (prescale),
        .tick     (tick),
        .count_out(count_out),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic bit model_tick(input bit st, input bit sp, input bit pa);
        return m_active && !m_frozen && !st && !sp && !pa &&
               (((m_elapsed + 1) % (m_pre + 1)) == 0);
    endfunction

    // One functional clock cycle: drive inputs, sample tick mid-cycle,
    // clock the DUT, then advance the model.
    task automatic drive_cycle(input bit st, input bit sp, input bit pa, input bit md,
                               input int unsigned per, input int unsigned pre);
        int unsigned ticks;
        int unsigned r;
        rst_n    = 1'b1;
        start    = st;
        stop     = sp;
        pause    = pa;
        mode     = md;
        period   = CNT_W'(per);
        prescale = PRE_W'(pre);
        m_tick   = model_tick(st, sp, pa);
        @(negedge clk);
        obs_tick = tick;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (sp) begin
            if (m_active) begin
                m_active  = 1'b0;
                m_frozen  = 1'b0;
                m_count   = '0;
                m_elapsed = 0;
            end
        end else if (st) begin
            if (per != 0) begin
                m_per      = per;
                m_pre      = pre;
                m_periodic = md;
                m_active   = 1'b1;
                m_frozen   = 1'b0;
                m_elapsed  = 0;
                m_count    = '0;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_active) begin
            if (pa) begin
                m_frozen = 1'b1;
            end else if (m_frozen) begin
                m_frozen = 1'b0;
            end else begin
                m_elapsed++;
                if ((m_elapsed % (m_pre + 1)) == 0) begin
                    ticks = m_elapsed / (m_pre + 1);
                    r     = ticks % (m_per + 1);
                    if (r == 0) begin
                        m_done = 1'b1;
                        if (m_periodic) begin
                            m_count = '0;
                        end else begin
                            m_active = 1'b0;
                            m_count  = CNT_W'(m_per);
                        end
                    end else begin
                        m_count = CNT_W'(r);
                    end
                end
            end
        end
    endtask

    task automatic drive_reset_cycle(input bit st, input bit sp, input bit pa);
        rst_n  = 1'b0;
        start  = st;
        stop   = sp;
        pause  = pa;
        m_tick = model_tick(st, sp, pa);
        @(negedge clk);
        obs_tick = tick;
        @(posedge clk);
        #1;
        m_active   = 1'b0;
        m_frozen   = 1'b0;
        m_elapsed  = 0;
        m_per      = 0;
        m_pre      = 0;
        m_periodic = 1'b0;
        m_count    = '0;
        m_done     = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        drive_reset_cycle(1'b0, 1'b0, 1'b0);
        drive_reset_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (count_out !== '0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial got count=%0d busy=%b done=%b err=%b exp 0/0/0/0",
                     count_out, busy, done, cfg_err);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 5, 0);
        for (int i = 0; i < 3; i++) idle_cycle();
        checks++;
        if (count_out !== 4'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_precount got count=%0d busy=%b exp 3/1", count_out, busy);
        end
        drive_reset_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (count_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_midrun got count=%0d busy=%b done=%b exp 0/0/0",
                     count_out, busy, done);
        end
        drive_reset_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_tick !== 1'b0 || count_out !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_held got tick=%b count=%0d done=%b exp 0/0/0",
                     obs_tick, count_out, done);
        end
    endtask

    task automatic test_oneshot();
        logic [CNT_W-1:0] exp_cnt;
        bit exp_done, exp_busy, exp_tick;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 3, 1);
        checks++;
        if (count_out !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_start got count=%0d busy=%b exp 0/1", count_out, busy);
        end
        for (int j = 1; j <= 9; j++) begin
            idle_cycle();
            exp_cnt  = (j < 8) ? CNT_W'(j / 2) : 4'd3;
            exp_done = (j == 8);
            exp_busy = (j < 8);
            exp_tick = ((j % 2) == 0) && (j <= 8);
            checks++;
            if (count_out !== exp_cnt || done !== exp_done || busy !== exp_busy ||
                obs_tick !== exp_tick) begin
                failures++;
                $display("FAIL oneshot j=%0d got count=%0d done=%b busy=%b tick=%b exp %0d/%b/%b/%b",
                         j, count_out, done, busy, obs_tick, exp_cnt, exp_done, exp_busy, exp_tick);
            end
        end
    endtask

    task automatic test_periodic();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 15, 0);
        for (int j = 1; j <= 40; j++) begin
            idle_cycle();
            checks++;
            if (count_out !== CNT_W'(j % 16) || done !== ((j % 16) == 0) || busy !== 1'b1 ||
                obs_tick !== 1'b1) begin
                failures++;
                $display("FAIL periodic j=%0d got count=%0d done=%b busy=%b tick=%b exp %0d/%b/1/1",
                         j, count_out, done, busy, obs_tick, j % 16, (j % 16) == 0);
            end
        end
    endtask

    task automatic test_pause();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
        idle_cycle();
        idle_cycle();
        for (int j = 3; j <= 5; j++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
            checks++;
            if (count_out !== 4'd2 || obs_tick !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL pause_hold j=%0d got count=%0d tick=%b busy=%b exp 2/0/1",
                         j, count_out, obs_tick, busy);
            end
        end
        for (int j = 6; j <= 11; j++) begin
            idle_cycle();
            checks++;
            if (count_out !== ((j <= 6) ? 4'd2 : (j >= 9) ? 4'd5 : CNT_W'(j - 4)) ||
                done !== (j == 10) || busy !== (j < 10) || obs_tick !== (j >= 7 && j <= 10)) begin
                failures++;
                $display("FAIL pause_resume j=%0d got count=%0d done=%b busy=%b tick=%b",
                         j, count_out, done, busy, obs_tick);
            end
        end
    endtask

    task automatic test_stop_start();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 9, 0);
        for (int i = 0; i < 4; i++) idle_cycle();
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 9, 0);
        checks++;
        if (count_out !== '0 || busy !== 1'b0 || done !== 1'b0 || obs_tick !== 1'b0) begin
            failures++;
            $display("FAIL stop_start got count=%0d busy=%b done=%b tick=%b exp 0/0/0/0",
                     count_out, busy, done, obs_tick);
        end
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            checks++;
            if (count_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL stop_idle got count=%0d busy=%b done=%b exp 0/0/0",
                         count_out, busy, done);
            end
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 9, 1);
        for (int i = 0; i < 5; i++) idle_cycle();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (cfg_err !== 1'b1 || count_out !== 4'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL cfg_err_pulse got err=%b count=%0d busy=%b exp 1/2/1",
                     cfg_err, count_out, busy);
        end
        for (int i = 0; i < 6; i++) begin
            idle_cycle();
            checks++;
            if (cfg_err !== 1'b0 || count_out !== m_count || busy !== 1'b1) begin
                failures++;
                $display("FAIL cfg_err_continue i=%0d got err=%b count=%0d busy=%b exp 0/%0d/1",
                         i, cfg_err, count_out, busy, m_count);
            end
        end
    endtask

    task automatic test_restart();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 7, 0);
        for (int i = 0; i < 5; i++) idle_cycle();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
        checks++;
        if (count_out !== '0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL restart_load got count=%0d busy=%b done=%b exp 0/1/0",
                     count_out, busy, done);
        end
        for (int j = 1; j <= 3; j++) begin
            idle_cycle();
            checks++;
            if (count_out !== ((j == 3) ? 4'd2 : CNT_W'(j)) || done !== (j == 3) ||
                busy !== (j < 3)) begin
                failures++;
                $display("FAIL restart j=%0d got count=%0d done=%b busy=%b", j, count_out, done, busy);
            end
        end
    endtask

    task automatic test_random();
        int unsigned r;
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 999);
            if (r < 5) begin
                drive_reset_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)));
            end else begin
                drive_cycle(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 2),
                            ($urandom_range(0, 99) < 12), 1'($urandom_range(0, 1)),
                            $urandom_range(0, 15), $urandom_range(0, 3));
            end
            checks++;
            if (obs_tick !== m_tick || count_out !== m_count || busy !== m_active ||
                done !== m_done || cfg_err !== m_err) begin
                failures++;
                $display("FAIL random n=%0d got tick=%b count=%0d busy=%b done=%b err=%b exp %b/%0d/%b/%b/%b",
                         n, obs_tick, count_out, busy, done, cfg_err,
                         m_tick, m_count, m_active, m_done, m_err);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        pause    = 1'b0;
        mode     = 1'b0;
        period   = '0;
        prescale = '0;
        m_count  = '0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_stop_start();
        test_restart();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
